fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//   Shares the single write port of one fifo instance among NUM_REQ producers.
//   - Round-robin arbitration with a one-entry registered output stage.
//   - Drives the fifo write port (wr_din/din) and honours the fifo full flag.
//   - Provides a flush sequence and a push counter for pipeline stage control.
// PARAMETERS
//   NUM_REQ    4  number of requesters (>=2)
//   DATA_BW    4  data width; matches the fifo DATA_BW
//   CNT_BW     8  width of the push counter
//   MAX_BURST  4  max consecutive grants to one requester (FIFO_ARB_BURST_EN only)
// PORTS
//   clk         in   1                clock
//   rst         in   1                reset; asynchronous, active-low
//   req         in   NUM_REQ          per-requester valid
//   req_data    in   NUM_REQ*DATA_BW  requester i data at [i*DATA_BW +: DATA_BW]
//   gnt         out  NUM_REQ          one-hot; requester i's data accepted this cycle
//   fifo_full   in   1                fifo full flag
//   fifo_wr_din out  1                fifo write enable
//   fifo_din    out  DATA_BW          fifo write data
//   flush       in   1                request drain; level, sampled in RUN
//   flush_done  out  1                one-cycle pulse: drain complete
//   busy        out  1                output register holds data
//   push_cnt    out  CNT_BW           total fifo writes, wraps modulo 2^CNT_BW
// BEHAVIOUR
//   Reset (rst=0): state=RUN, out_valid=0, out_data=0, rr_ptr=0, push_cnt=0,
//     gnt=0, fifo_wr_din=0, fifo_din=0, flush_done=0, busy=0. Applies immediately.
//     Reset mid-transfer discards the held word; nothing is written to the fifo.
//   Output stage:
//     - fifo_wr_din = out_valid & ~fifo_full (combinational). fifo_din = out_data.
//     - drain = fifo_wr_din. Slot is free when ~out_valid | drain.
//   Arbitration: combinational, active only in RUN and only when the slot is free.
//     - Winner = first i with req[i]=1, scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//     - gnt[winner]=1. Next edge: out_data<=req_data[winner], out_valid<=1,
//       rr_ptr<=(winner+1) mod NUM_REQ.
//     - No winner while draining: out_valid<=0.
//     - Latency: gnt in cycle N gives fifo_wr_din in cycle N+1 if the fifo is not full.
//     - Drain plus new grant in the same cycle sustains 1 word/cycle.
//     - fifo_full=1 with out_valid=1: hold out_data, gnt=0, rr_ptr unchanged.
//   push_cnt increments on every cycle with fifo_wr_din=1; rolls from 2^CNT_BW-1 to 0.
//   busy = out_valid.
//   FSM:
//     RUN   -> DRAIN when flush=1. Grants still allowed in that same cycle.
//     DRAIN:  gnt forced 0. Moves to DONE once out_valid=0 at the clock edge.
//     DONE:   flush_done=1 for one cycle, gnt=0. Then returns to RUN regardless of flush.
//     flush raised again in RUN starts a new sequence.
//     flush with out_valid=0: RUN -> DRAIN -> DONE, pulse on the 2nd cycle.
//   The bypass rule is fixed: req is never forwarded to the fifo in the same
//   cycle it is granted.
// CONFIGURATION
//   FIFO_ARB_BURST_EN defined:
//     - A burst counter (0..MAX_BURST-1) runs while the same requester wins
//       consecutive grants.
//     - rr_ptr stays on the last winner while it keeps req=1 and count < MAX_BURST-1.
//     - On the MAX_BURST-th consecutive grant, or when that requester deasserts
//       req, rr_ptr advances as normal and the counter clears.
//     - Reset and DONE clear the counter.
//   FIFO_ARB_BURST_EN undefined:
//     - Strict round-robin as above. MAX_BURST is unused; no burst counter is built.
// TESTING
//   1 Reset: rst=0 with req=4'b1111 -> gnt=0, fifo_wr_din=0, push_cnt=0, busy=0.
//   2 Round-robin: req=4'b1111 held, fifo_full=0 -> gnt 0001,0010,0100,1000,0001.
//     fifo_din follows one cycle later; push_cnt=4 after 5 cycles.
//   3 Backpressure: fifo_full=1 while out_valid=1 -> gnt=0 and fifo_din held.
//     Release full -> word written once, then grants resume from the same rr_ptr.
//   4 Flush: req=4'b0100, assert flush -> one final grant, DRAIN, write.
//     flush_done pulses exactly 1 cycle, then RUN resumes.
//   5 Wrap: CNT_BW=8, preload 255 pushes, push once more -> push_cnt=0.
//   6 FIFO_ARB_BURST_EN, MAX_BURST=4, req=4'b0011 -> gnt 0001 x4 then 0010 x4.
//     Without the macro: alternates 0001,0010.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one fifo write port among NUM_REQ producers, with flush FSM and push counter.
// Optional burst mode: define FIFO_ARB_BURST_EN to allow up to MAX_BURST consecutive grants per requester.
module fifo_wr_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned DATA_BW   = 4,
    parameter int unsigned CNT_BW    = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*DATA_BW-1:0] req_data,
    output logic [NUM_REQ-1:0]         gnt,
    input  logic                       fifo_full,
    output logic                       fifo_wr_din,
    output logic [DATA_BW-1:0]         fifo_din,
    input  logic                       flush,
    output logic                       flush_done,
    output logic                       busy,
    output logic [CNT_BW-1:0]          push_cnt
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || MAX_BURST < 1) begin : g_bad_cfg
        $error("fifo_wr_arbiter: NUM_REQ must be >= 2 and MAX_BURST >= 1");
    end

    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

    state_t             state;
    logic               out_valid;
    logic [DATA_BW-1:0] out_data;
    logic [PTR_W-1:0]   rr_ptr;

    logic               drain;
    logic               slot_free;
    logic               arb_en;
    logic               win_found;
    logic               grant_any;
    logic [PTR_W-1:0]   win_idx;
    logic [PTR_W-1:0]   win_inc;
    logic [PTR_W-1:0]   ptr_nxt;
    logic [DATA_BW-1:0] win_data;

    assign drain       = out_valid & ~fifo_full;
    assign fifo_wr_din = drain;
    assign fifo_din    = out_data;
    assign busy        = out_valid;
    assign flush_done  = (state == DONE);
    assign slot_free   = ~out_valid | drain;
    // rst gating keeps gnt low while reset is held, since arbitration is combinational
    assign arb_en      = rst & (state == RUN) & slot_free;
    assign grant_any   = arb_en & win_found;
    assign gnt         = grant_any ? (NUM_REQ'(1) << win_idx) : '0;
    assign win_data    = req_data[32'(win_idx)*DATA_BW +: DATA_BW];
    assign win_inc     = (32'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + PTR_W'(1);

    // First requester at or after rr_ptr, circularly
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!win_found && req[PTR_W'((32'(rr_ptr) + k) % NUM_REQ)]) begin
                win_found = 1'b1;
                win_idx   = PTR_W'((32'(rr_ptr) + k) % NUM_REQ);
            end
        end
    end

`ifdef FIFO_ARB_BURST_EN
    localparam int unsigned BURST_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    logic [BURST_W-1:0] burst_cnt;
    logic [BURST_W-1:0] cnt_nxt;
    logic [31:0]        taken;
    logic [PTR_W-1:0]   ptr_inc;
    logic               burst_stale;

    // burst_cnt counts grants already taken by the rr_ptr owner in its current burst
    always_comb begin
        taken   = (win_idx == rr_ptr) ? 32'(burst_cnt) + 32'd1 : 32'd1;
        ptr_nxt = win_idx;
        cnt_nxt = BURST_W'(taken);
        if (taken >= MAX_BURST) begin
            ptr_nxt = win_inc;
            cnt_nxt = '0;
        end
    end

    assign ptr_inc     = (32'(rr_ptr) == NUM_REQ - 1) ? '0 : rr_ptr + PTR_W'(1);
    assign burst_stale = (state == RUN) && !grant_any && (burst_cnt != '0) && !req[rr_ptr];
`else
    assign ptr_nxt = win_inc;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            out_valid <= 1'b0;
            out_data  <= '0;
            rr_ptr    <= '0;
            push_cnt  <= '0;
`ifdef FIFO_ARB_BURST_EN
            burst_cnt <= '0;
`endif
        end else begin
            if (drain) begin
                push_cnt <= push_cnt + CNT_BW'(1);
            end

            if (grant_any) begin
                out_data  <= win_data;
                out_valid <= 1'b1;
                rr_ptr    <= ptr_nxt;
            end else if (drain) begin
                out_valid <= 1'b0;
            end

`ifdef FIFO_ARB_BURST_EN
            if (grant_any) begin
                burst_cnt <= cnt_nxt;
            end else if (state == DONE) begin
                burst_cnt <= '0;
            end else if (burst_stale) begin
                burst_cnt <= '0;
                rr_ptr    <= ptr_inc;
            end
`endif

            case (state)
                RUN:     if (flush) state <= DRAIN;
                DRAIN:   if (!out_valid) state <= DONE;
                DONE:    state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter: reset, round-robin, backpressure, flush, wrap, burst.
module tb_fifo_wr_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] req_data;
    logic [3:0]  gnt;
    logic        fifo_full;
    logic        fifo_wr_din;
    logic [3:0]  fifo_din;
    logic        flush;
    logic        flush_done;
    logic        busy;
    logic [7:0]  push_cnt;

    int n_checks;
    int n_fail;

    fifo_wr_arbiter #(
        .NUM_REQ(4), .DATA_BW(4), .CNT_BW(8), .MAX_BURST(4)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
        .fifo_full(fifo_full), .fifo_wr_din(fifo_wr_din), .fifo_din(fifo_din),
        .flush(flush), .flush_done(flush_done), .busy(busy), .push_cnt(push_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        req       = '0;
        flush     = 1'b0;
        fifo_full = 1'b0;
        req_data  = 16'hDCBA;
        next_cycle();
        next_cycle();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        req       = 4'b1111;
        flush     = 1'b0;
        fifo_full = 1'b0;
        req_data  = 16'hDCBA;
        @(negedge clk);
        n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
        n_checks++; if (fifo_wr_din !== 1'b0) begin n_fail++; $display("FAIL reset_wr: got %b want 0", fifo_wr_din); end
        n_checks++; if (push_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", push_cnt); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (flush_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", flush_done); end
        n_checks++; if (fifo_din !== 4'h0) begin n_fail++; $display("FAIL reset_din: got %h want 0", fifo_din); end
        // Reset while a word is held discards it immediately
        next_cycle();
        rst = 1'b1;
        req = 4'b0001;
        next_cycle();
        @(negedge clk);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_busy: got %b want 1", busy); end
        rst = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy); end
        n_checks++; if (fifo_wr_din !== 1'b0) begin n_fail++; $display("FAIL midrst_wr: got %b want 0", fifo_wr_din); end
        n_checks++; if (push_cnt !== 8'd0) begin n_fail++; $display("FAIL midrst_cnt: got %0d want 0", push_cnt); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_gnt [5];
        logic       exp_wr  [5];
        logic [3:0] exp_din [5];
        exp_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_wr  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        exp_din = '{4'h0, 4'hA, 4'hB, 4'hC, 4'hD};
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++; if (gnt !== exp_gnt[i]) begin n_fail++; $display("FAIL rr_gnt[%0d]: got %b want %b", i, gnt, exp_gnt[i]); end
            n_checks++; if (fifo_wr_din !== exp_wr[i]) begin n_fail++; $display("FAIL rr_wr[%0d]: got %b want %b", i, fifo_wr_din, exp_wr[i]); end
            if (exp_wr[i]) begin
                n_checks++; if (fifo_din !== exp_din[i]) begin n_fail++; $display("FAIL rr_din[%0d]: got %h want %h", i, fifo_din, exp_din[i]); end
            end
            next_cycle();
        end
        @(negedge clk);
        n_checks++; if (push_cnt !== 8'd4) begin n_fail++; $display("FAIL rr_cnt: got %0d want 4", push_cnt); end
    endtask

    task automatic test_backpressure();
        do_reset();
        req = 4'b0011;
        @(negedge clk);
        n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL bp_first_gnt: got %b want 0001", gnt); end
        next_cycle();
        fifo_full = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL bp_full_gnt[%0d]: got %b want 0000", i, gnt); end
            n_checks++; if (fifo_wr_din !== 1'b0) begin n_fail++; $display("FAIL bp_full_wr[%0d]: got %b want 0", i, fifo_wr_din); end
            n_checks++; if (fifo_din !== 4'hA) begin n_fail++; $display("FAIL bp_hold_din[%0d]: got %h want a", i, fifo_din); end
            next_cycle();
        end
        fifo_full = 1'b0;
        @(negedge clk);
        n_checks++; if (fifo_wr_din !== 1'b1) begin n_fail++; $display("FAIL bp_release_wr: got %b want 1", fifo_wr_din); end
        n_checks++; if (fifo_din !== 4'hA) begin n_fail++; $display("FAIL bp_release_din: got %h want a", fifo_din); end
        n_checks++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL bp_resume_gnt: got %b want 0010", gnt); end
        next_cycle();
        @(negedge clk);
        n_checks++; if (push_cnt !== 8'd1) begin n_fail++; $display("FAIL bp_cnt: got %0d want 1", push_cnt); end
        n_checks++; if (fifo_din !== 4'hB) begin n_fail++; $display("FAIL bp_next_din: got %h want b", fifo_din); end
    endtask

    task automatic test_flush();
        do_reset();
        req   = 4'b0100;
        flush = 1'b1;
        @(negedge clk);
        n_checks++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL fl_final_gnt: got %b want 0100", gnt); end
        next_cycle();
        flush = 1'b0;
        @(negedge clk);
        n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL fl_drain_gnt: got %b want 0000", gnt); end
        n_checks++; if (fifo_wr_din !== 1'b1 || fifo_din !== 4'hC) begin n_fail++; $display("FAIL fl_drain_wr: got wr=%b din=%h want wr=1 din=c", fifo_wr_din, fifo_din); end
        n_checks++; if (flush_done !== 1'b0) begin n_fail++; $display("FAIL fl_done_early1: got %b want 0", flush_done); end
        next_cycle();
        @(negedge clk);
        n_checks++; if (busy !== 1'b0 || gnt !== 4'b0000 || flush_done !== 1'b0) begin n_fail++; $display("FAIL fl_empty: got busy=%b gnt=%b done=%b want 0 0000 0", busy, gnt, flush_done); end
        next_cycle();
        @(negedge clk);
        n_checks++; if (flush_done !== 1'b1) begin n_fail++; $display("FAIL fl_done_pulse: got %b want 1", flush_done); end
        n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL fl_done_gnt: got %b want 0000", gnt); end
        next_cycle();
        @(negedge clk);
        n_checks++; if (flush_done !== 1'b0) begin n_fail++; $display("FAIL fl_done_width: got %b want 0", flush_done); end
        n_checks++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL fl_resume_gnt: got %b want 0100", gnt); end
        n_checks++; if (push_cnt !== 8'd1) begin n_fail++; $display("FAIL fl_cnt: got %0d want 1", push_cnt); end
    endtask

    task automatic test_wrap();
        do_reset();
        req = 4'b0001;
        repeat (256) next_cycle();
        @(negedge clk);
        n_checks++; if (push_cnt !== 8'd255) begin n_fail++; $display("FAIL wrap_pre: got %0d want 255", push_cnt); end
        n_checks++; if (fifo_wr_din !== 1'b1) begin n_fail++; $display("FAIL wrap_wr: got %b want 1", fifo_wr_din); end
        next_cycle();
        @(negedge clk);
        n_checks++; if (push_cnt !== 8'd0) begin n_fail++; $display("FAIL wrap_post: got %0d want 0", push_cnt); end
    endtask

    task automatic test_burst();
        logic [3:0] exp_gnt [8];
`ifdef FIFO_ARB_BURST_EN
        exp_gnt = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0010};
`else
        exp_gnt = '{4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0001, 4'b0010};
`endif
        do_reset();
        req = 4'b0011;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_checks++; if (gnt !== exp_gnt[i]) begin n_fail++; $display("FAIL burst_gnt[%0d]: got %b want %b", i, gnt, exp_gnt[i]); end
            next_cycle();
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_round_robin();
        test_backpressure();
        test_flush();
        test_wrap();
        test_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
